gate_sweep_checker: RTL and testbench

- Self-checking stimulus/response engine for single-output combinational gate DUTs (AND, OR, XOR, ...). The generic gate fixture only drives inputs; this block is the response end of that interface.
- On START it drives every input vector onto the DUT in ascending order and waits a settle time per vector.
- It then samples the DUT output and compares it against a parameterised truth table.
- It reports the error count, the first failing vector and a pass/fail verdict. It sits in lab benches and on-board self-test wrappers next to the gate under test.

---
 rtl/gate_sweep_checker.sv | 134 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps every input vector of a single-output gate and
// compares the gate's output against the truth table EXP_TT.
//
// Parameters:
//   N_IN   number of gate inputs (1..8)
//   SETTLE wait cycles per vector before sampling (1..255)
//   EXP_TT expected truth table, bit i = expected output for vector i
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   START      begin a sweep (only looked at while idle)
//   DUT_I      vector driven to the gate, bit 0 = gate input I1
//   DUT_O      gate output under test
//   BUSY       sweep in progress
//   DONE       one-cycle pulse at sweep end
//   PASS       verdict of the last completed sweep
//   ERR_CNT    number of mismatching vectors
//   FAIL_SEEN  at least one mismatch in the current/last sweep
//   FIRST_FAIL first mismatching vector (valid when FAIL_SEEN=1)
//
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first
// mismatch instead of running every vector.

module gate_sweep_checker #(
    parameter int N_IN = 2,
    parameter int SETTLE = 2,
    parameter logic [(1 << N_IN) - 1:0] EXP_TT = 4'b1000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    output logic [N_IN-1:0] DUT_I,
    input  logic            DUT_O,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [N_IN:0]   ERR_CNT,
    output logic            FAIL_SEEN,
    output logic [N_IN-1:0] FIRST_FAIL
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_FINISH
    } state_t;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

    state_t     state;
    logic [7:0] cnt;
    logic       mismatch;
    logic       last_vec;

    assign mismatch = (DUT_O != EXP_TT[DUT_I]);
    assign last_vec = (DUT_I == VEC_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            DUT_I      <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_SEEN  <= 1'b0;
            FIRST_FAIL <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        DUT_I      <= '0;
                        ERR_CNT    <= '0;
                        FAIL_SEEN  <= 1'b0;
                        FIRST_FAIL <= '0;
                        PASS       <= 1'b0;
                        cnt        <= '0;
                        BUSY       <= 1'b1;
                        state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == SETTLE_LAST) begin
                        state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    if (mismatch) begin
                        ERR_CNT <= ERR_CNT + ERR_ONE;
                        if (!FAIL_SEEN) begin
                            FIRST_FAIL <= DUT_I;
                            FAIL_SEEN  <= 1'b1;
                        end
                    end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                    // First mismatch ends the sweep; DUT_I keeps the
                    // failing vector.
                    if (mismatch || last_vec) begin
`else
                    if (last_vec) begin
`endif
                        DONE  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        DUT_I <= DUT_I + VEC_ONE;
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end

                S_FINISH: begin
                    PASS  <= (ERR_CNT == '0);
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: randomized sweeps of a modelled gate, checked by a
// scoreboard fed from a truth-table level reference model.

module tb_gate_sweep_checker;

    localparam int N_IN = 2;
    localparam int SETTLE = 2;
    localparam int NV = 1 << N_IN;
    localparam logic [NV-1:0] EXP_TT = 4'b1000;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            START = 1'b0;
    logic [N_IN-1:0] DUT_I;
    logic            DUT_O;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [N_IN:0]   ERR_CNT;
    logic            FAIL_SEEN;
    logic [N_IN-1:0] FIRST_FAIL;

    logic [NV-1:0] act_tt = EXP_TT;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int err;
        bit fs;
        int ff;
        bit pass;
        int done_edge;
        int last_vec;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   pass_pending = 0;

    gate_sweep_checker #(
        .N_IN(N_IN),
        .SETTLE(SETTLE),
        .EXP_TT(EXP_TT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .DUT_I(DUT_I),
        .DUT_O(DUT_O),
        .BUSY(BUSY),
        .DONE(DONE),
        .PASS(PASS),
        .ERR_CNT(ERR_CNT),
        .FAIL_SEEN(FAIL_SEEN),
        .FIRST_FAIL(FIRST_FAIL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Gate under test: whatever truth table the stimulus selects.
    assign DUT_O = act_tt[DUT_I];

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, expv, cyc);
        end
    endtask

    // Reference: mismatch set is the XOR of the gate's table and EXP_TT.
    function automatic exp_t model(input logic [NV-1:0] tt, input int start);
        exp_t e;
        logic [NV-1:0] mism;
        bit stopped;
        int nvec;
        mism = tt ^ EXP_TT;
        e.err = 0;
        e.fs = 0;
        e.ff = 0;
        stopped = 0;
        for (int v = 0; v < NV; v++) begin
            if (!stopped && mism[v]) begin
                if (!e.fs) begin
                    e.fs = 1;
                    e.ff = v;
                end
                e.err++;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                stopped = 1;
`endif
            end
        end
        e.last_vec = stopped ? e.ff : NV - 1;
        nvec = e.last_vec + 1;
        e.done_edge = start + nvec * (SETTLE + 1);
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Monitor: pops on DONE, checks PASS/BUSY one cycle later.
    always @(negedge CLK) begin
        if (pass_pending) begin
            pass_pending = 0;
            check("pass", int'(PASS), int'(cur.pass));
            check("busy_after", int'(BUSY), 0);
        end
        if (DONE) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur = sb.pop_front();
                check("done_edge", cyc, cur.done_edge);
                check("err_cnt", int'(ERR_CNT), cur.err);
                check("fail_seen", int'(FAIL_SEEN), int'(cur.fs));
                if (cur.fs) check("first_fail", int'(FIRST_FAIL), cur.ff);
                check("dut_i_end", int'(DUT_I), cur.last_vec);
                check("busy_done", int'(BUSY), 1);
                pass_pending = 1;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || pass_pending) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0 || pass_pending) begin
            check("timeout", 1, 0);
            sb.delete();
            pass_pending = 0;
        end
        @(negedge CLK);
    endtask

    // One sweep; optionally toggles START randomly while busy.
    task automatic run_sweep(input logic [NV-1:0] tt, input bit noise);
        exp_t e;
        act_tt = tt;
        START = 1'b1;
        e = model(tt, cyc + 1);
        sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        if (noise) begin
            while (cyc <= e.done_edge) begin
                START = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            START = 1'b0;
        end
        drain();
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        logic [NV-1:0] rtt;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_pass", int'(PASS), 0);
        check("rst_err", int'(ERR_CNT), 0);
        check("rst_fs", int'(FAIL_SEEN), 0);
        check("rst_ff", int'(FIRST_FAIL), 0);
        check("rst_dut_i", int'(DUT_I), 0);
        @(negedge CLK);

        run_sweep(EXP_TT, 0);
        run_sweep('0, 0);
        run_sweep(4'b1110, 0);
        run_sweep(4'b0111, 1);
        run_sweep('1, 0);

        // Reset at edge 5 of a sweep aborts without DONE.
        act_tt = EXP_TT;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", int'(BUSY), 0);
        check("abort_dut_i", int'(DUT_I), 0);
        check("abort_err", int'(ERR_CNT), 0);
        repeat (20) @(negedge CLK);
        run_sweep(EXP_TT, 0);

        // START held high: second sweep accepted one cycle after idle.
        act_tt = 4'b1110;
        START = 1'b1;
        e1 = model(act_tt, cyc + 1);
        e2 = model(act_tt, e1.done_edge + 2);
        sb.push_back(e1);
        sb.push_back(e2);
        while (cyc < e2.done_edge - e1.done_edge + 1) @(negedge CLK);
        while (cyc < e1.done_edge + 2) @(negedge CLK);
        START = 1'b0;
        drain();

        for (int k = 0; k < 8; k++) begin
            rtt = NV'($urandom_range(0, NV - 1) | ($urandom() & 32'hF));
            run_sweep(rtt, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
